// File: rtl/mux16_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mux16_scan_ctrl
// Brief   : Scan sequencer for a 16:1 strobed mux; builds a 16-bit snapshot.
// Revision: 1.0 - initial release
// ============================================================================
module mux16_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        continuous,
    input  logic [15:0] ch_enable,
    input  logic        mux_out,
    output logic [3:0]  mux_sel,
    output logic        mux_strobe,
    output logic [15:0] scan_data,
    output logic        data_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  sel_nxt;
    logic [15:0] mask, mask_nxt;
    logic [15:0] shadow, shadow_nxt;
    logic [15:0] scan_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        dv_nxt;
    logic [4:0]  first_en;
    logic [4:0]  next_en;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [4:0] first_set(input logic [15:0] v);
        first_set = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) first_set = {1'b1, 4'(i)};
        end
    endfunction

    assign first_en   = first_set(ch_enable);
    // Only channels strictly above the current one; shift-out at 15 leaves none.
    assign next_en    = first_set(mask & ~((16'd2 << mux_sel) - 16'd1));
    assign mux_strobe = !((state == SETTLE) || (state == SAMPLE));
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        sel_nxt    = mux_sel;
        mask_nxt   = mask;
        shadow_nxt = shadow;
        scan_nxt   = scan_data;
        cnt_nxt    = cnt;
        dv_nxt     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if ((state == IDLE && start) || (state == DONE && continuous)) begin
                    mask_nxt   = ch_enable;
                    shadow_nxt = 16'd0;
                    if (first_en[4]) begin
                        state_nxt = SELECT;
                        sel_nxt   = first_en[3:0];
                    end else begin
                        state_nxt = DONE;
                        scan_nxt  = 16'd0;
                        dv_nxt    = 1'b1;
                    end
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                    sel_nxt   = 4'd0;
                end
            end
            SELECT: begin
                cnt_nxt   = SETTLE_LOAD;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd0) state_nxt = SAMPLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            SAMPLE: begin
                shadow_nxt[mux_sel] = mux_out;
                if (next_en[4]) begin
                    state_nxt = SELECT;
                    sel_nxt   = next_en[3:0];
                end else begin
                    // Publish together with the final sample so data and pulse align.
                    state_nxt = DONE;
                    scan_nxt  = shadow_nxt;
                    dv_nxt    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mux_sel    <= 4'd0;
            mask       <= 16'd0;
            shadow     <= 16'd0;
            scan_data  <= 16'd0;
            cnt        <= 4'd0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            mux_sel    <= sel_nxt;
            mask       <= mask_nxt;
            shadow     <= shadow_nxt;
            scan_data  <= scan_nxt;
            cnt        <= cnt_nxt;
            data_valid <= dv_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux16_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux16_scan_ctrl
// Brief   : Directed self-checking bench for mux16_scan_ctrl (SETTLE_CYCLES=2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        continuous;
    logic [15:0] ch_enable;
    logic        mux_out;
    logic [3:0]  mux_sel;
    logic        mux_strobe;
    logic [15:0] scan_data;
    logic        data_valid;
    logic        busy;

    logic [15:0] pattern;
    logic [3:0]  prev_sel;
    int          cyc;
    int          n_tests;
    int          n_fail;
    int          dv_at;
    int          visited[$];

    mux16_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .ch_enable  (ch_enable),
        .mux_out    (mux_out),
        .mux_sel    (mux_sel),
        .mux_strobe (mux_strobe),
        .scan_data  (scan_data),
        .data_valid (data_valid),
        .busy       (busy)
    );

    // Mux model: strobe forces the output high.
    assign mux_out = mux_strobe ? 1'b1 : pattern[mux_sel];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle; observe 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (mux_sel != prev_sel) check("strobe_on_sel_change", 32'(mux_strobe), 32'd1);
        prev_sel = mux_sel;
        if (busy && mux_strobe && !data_valid) visited.push_back(int'(mux_sel));
    endtask

    task automatic start_scan(input logic [15:0] en);
        visited.delete();
        ch_enable = en;
        start     = 1'b1;
        cyc       = 0;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_dv(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            step();
            if (data_valid) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; ch_enable = 16'h0000;
        pattern = 16'hA5C3; prev_sel = 4'd0;
        #12;
        check("rst_sel",    32'(mux_sel),    32'd0);
        check("rst_strobe", 32'(mux_strobe), 32'd1);
        check("rst_data",   32'(scan_data),  32'd0);
        check("rst_dv",     32'(data_valid), 32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        step();
        rst = 1'b0;
        step();

        // 1: full scan
        start_scan(16'hFFFF);
        wait_dv(100, dv_at);
        check("t1_dv_cycle", 32'(dv_at), 32'd65);
        check("t1_data", 32'(scan_data), 32'h0000A5C3);
        check("t1_visits", 32'(visited.size()), 32'd16);
        if (visited.size() == 16)
            for (int i = 0; i < 16; i++) check("t1_order", 32'(visited[i]), 32'(i));
        step();
        check("t1_busy_low", 32'(busy), 32'd0);

        // 2: sparse enable
        pattern = 16'hFFFF;
        start_scan(16'h0011);
        wait_dv(100, dv_at);
        check("t2_dv_cycle", 32'(dv_at), 32'd9);
        check("t2_data", 32'(scan_data), 32'h00000011);
        check("t2_visits", 32'(visited.size()), 32'd2);
        if (visited.size() == 2) begin
            check("t2_first",  32'(visited[0]), 32'd0);
            check("t2_second", 32'(visited[1]), 32'd4);
        end
        step();

        // 3: nothing enabled
        start_scan(16'h0000);
        check("t3_dv_cycle1", 32'(data_valid), 32'd1);
        check("t3_data",   32'(scan_data),  32'd0);
        check("t3_strobe", 32'(mux_strobe), 32'd1);
        check("t3_visits", 32'(visited.size()), 32'd0);
        step();
        check("t3_idle", 32'(busy), 32'd0);

        // 4: continuous, dropped mid-scan
        pattern    = 16'hA5C3;
        continuous = 1'b1;
        start_scan(16'hFFFF);
        wait_dv(100, dv_at);
        check("t4_dv1_cycle", 32'(dv_at), 32'd65);
        check("t4_data1", 32'(scan_data), 32'h0000A5C3);
        pattern = 16'h3C5A;
        while (cyc < 100) step();
        continuous = 1'b0;
        wait_dv(100, dv_at);
        check("t4_dv2_cycle", 32'(dv_at), 32'd130);
        check("t4_data2", 32'(scan_data), 32'h00003C5A);
        step();
        check("t4_idle", 32'(busy), 32'd0);

        // 5: reset mid-scan
        start_scan(16'hFFFF);
        for (int i = 0; i < 40 && mux_sel != 4'd7; i++) step();
        check("t5_reached7", 32'(mux_sel), 32'd7);
        #2 rst = 1'b1;
        #1;
        check("t5_sel",    32'(mux_sel),    32'd0);
        check("t5_strobe", 32'(mux_strobe), 32'd1);
        check("t5_busy",   32'(busy),       32'd0);
        check("t5_data",   32'(scan_data),  32'd0);
        step();
        rst = 1'b0;
        start_scan(16'hFFFF);
        check("t5_restart_sel", 32'(mux_sel), 32'd0);
        wait_dv(100, dv_at);
        check("t5_dv_cycle", 32'(dv_at), 32'd65);
        check("t5_data2", 32'(scan_data), 32'h00003C5A);
        step();

        // 6: start and enable changes while busy are ignored
        pattern = 16'h5A5A;
        start_scan(16'h00F0);
        step(); step(); step();
        start = 1'b1; ch_enable = 16'hFFFF;
        step();
        start = 1'b0;
        wait_dv(100, dv_at);
        check("t6_dv_cycle", 32'(dv_at), 32'd17);
        check("t6_data", 32'(scan_data), 32'h00000050);
        check("t6_visits", 32'(visited.size()), 32'd4);
        if (visited.size() == 4) begin
            check("t6_first", 32'(visited[0]), 32'd4);
            check("t6_last",  32'(visited[3]), 32'd7);
        end
        step();
        check("t6_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
